// File: rtl/theta_phase_gen_pkg.sv
// Shared constants and helpers for the phase-to-angle path.
// theta is IEEE-754 single; the packer relies on a 64-bit Q3.61 product.
package theta_phase_gen_pkg;

  localparam int unsigned SINGLE = 32;
  localparam int unsigned ProdW  = 64;

  // 127 (bias) + 63 (msb index of a 64-bit word) - 61 (Q3.61 fraction bits)
  localparam logic [7:0] ExpBase = 8'd129;

  function automatic logic [6:0] clz64(input logic [ProdW-1:0] v);
    logic [6:0] n;
    n = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = 7'(63 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/theta_phase_gen_phase_to_float.sv
// Normalizes the unsigned Q3.61 angle product and packs it with the sign
// into an IEEE-754 single. One register stage; theta holds between events.
module phase_to_float
  import theta_phase_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sign,
  input  logic [ProdW-1:0]  prod,
  input  logic              valid,
  output logic [SINGLE-1:0] theta,
  output logic              theta_valid
);

  logic [6:0]        lz;
  logic [ProdW-1:0]  norm;
  logic [7:0]        exp_field;
  logic [22:0]       mant;
  logic [SINGLE-1:0] theta_d;
  logic [SINGLE-1:0] theta_q;
  logic              valid_q;

  always_comb begin
    lz        = clz64(prod);
    norm      = prod << lz;
    exp_field = ExpBase - {1'b0, lz};
    // Bit 63 of norm is the implicit one; keep the 23 bits below it, truncated.
    mant      = 23'(norm >> 40);
    theta_d   = (prod == '0) ? '0 : {sign, exp_field, mant};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      theta_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid;
      if (valid) theta_q <= theta_d;
    end
  end

  assign theta       = theta_q;
  assign theta_valid = valid_q;

endmodule

// File: rtl/theta_phase_gen.sv
// Phase accumulator feeding the float sine stage: turns a per-step frequency
// word into a radian angle in [-pi, pi) with a fixed 3-cycle latency.
module theta_phase_gen
  import theta_phase_gen_pkg::*;
#(
  parameter int unsigned PHASE_W  = 32,
  parameter logic [31:0] TWO_PI_Q = 32'hC90FDAA2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               sync,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [PHASE_W-1:0] phase,
  output logic [SINGLE-1:0]  theta,
  output logic               theta_valid
);

  logic [PHASE_W-1:0] phase_d, phase_q;
  logic               ev_d, ev_q;

  logic               sign1_q;
  logic [PHASE_W-1:0] mag1_d, mag1_q;
  logic               v1_q;

  logic               sign2_q;
  logic [ProdW-1:0]   prod2_d, prod2_q;
  logic               v2_q;

  always_comb begin
    phase_d = phase_q;
    ev_d    = 1'b0;
    if (sync) begin
      phase_d = phase_offset;
      ev_d    = 1'b1;
    end else if (step) begin
      phase_d = phase_q + freq_word;
      ev_d    = 1'b1;
    end
  end

  // Signed fraction of a turn; -0.5 turn keeps its sign with magnitude 2^31.
  always_comb begin
    mag1_d  = phase_q[PHASE_W-1] ? -phase_q : phase_q;
    prod2_d = ProdW'(mag1_q) * ProdW'(TWO_PI_Q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      ev_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      v1_q    <= 1'b0;
      sign2_q <= 1'b0;
      prod2_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ev_q    <= ev_d;
      sign1_q <= phase_q[PHASE_W-1];
      mag1_q  <= mag1_d;
      v1_q    <= ev_q;
      sign2_q <= sign1_q;
      prod2_q <= prod2_d;
      v2_q    <= v1_q;
    end
  end

  phase_to_float u_phase_to_float (
    .clk         (clk),
    .rst         (rst),
    .sign        (sign2_q),
    .prod        (prod2_q),
    .valid       (v2_q),
    .theta       (theta),
    .theta_valid (theta_valid)
  );

  assign phase = phase_q;

endmodule

// File: tb/tb_theta_phase_gen.sv
// Randomized and directed bench for theta_phase_gen against an arithmetic
// model of the phase-to-radian conversion and a 3-cycle event schedule.
module tb_theta_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step = 1'b0;
  logic        sync = 1'b0;
  logic [31:0] freq_word = '0;
  logic [31:0] phase_offset = '0;
  logic [31:0] phase;
  logic [31:0] theta;
  logic        theta_valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    logic [31:0] th;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  logic [31:0] ref_phase = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_theta = '0;

  always #5 clk = ~clk;

  theta_phase_gen dut (
    .clk          (clk),
    .rst          (rst),
    .step         (step),
    .sync         (sync),
    .freq_word    (freq_word),
    .phase_offset (phase_offset),
    .phase        (phase),
    .theta        (theta),
    .theta_valid  (theta_valid)
  );

  // angle = (signed phase / 2^32) * 2pi, built from |phase| * 2pi(Q3.29)
  function automatic logic [31:0] ref_theta(input logic [31:0] ph);
    longint unsigned m, p, tmp, mant;
    int              e;
    logic            s;
    s = ph[31];
    m = s ? (64'h1_0000_0000 - {32'h0, ph}) : {32'h0, ph};
    p = m * 64'hC90FDAA2;
    if (p == 0) return 32'h0;
    e   = -1;
    tmp = p;
    while (tmp != 0) begin
      tmp = tmp >> 1;
      e++;
    end
    mant = (p >> (e - 23)) % 64'h80_0000;
    return {s, 8'(127 + e - 61), 23'(mant)};
  endfunction

  task automatic model_clear();
    pend.delete();
    ref_phase = '0;
    exp_valid = 1'b0;
    exp_theta = '0;
  endtask

  task automatic tick(input logic st, input logic sy, input logic [31:0] fw,
                      input logic [31:0] off);
    step = st;
    sync = sy;
    freq_word = fw;
    phase_offset = off;
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    if (sy) ref_phase = off;
    else if (st) ref_phase = ref_phase + fw;
    if (sy || st) pend.push_back('{due: cyc + 3, th: ref_theta(ref_phase)});
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_theta = pend[0].th;
      void'(pend.pop_front());
    end
    step = 1'b0;
    sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (phase !== 32'h0 || theta !== 32'h0 || theta_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: phase=%h theta=%h valid=%b, required 0/0/0",
               phase, theta, theta_valid);
    end
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    n_cmp++;
    if (phase !== 32'h0) begin
      n_bad++;
      $display("FAIL sync_zero_phase: phase=%h required 00000000", phase);
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (theta_valid !== 1'b1 || theta !== 32'h0) begin
      n_bad++;
      $display("FAIL sync_zero_theta: valid=%b theta=%h, required 1/00000000",
               theta_valid, theta);
    end
  endtask

  task automatic test_sync_vectors();
    logic [31:0] offs[4];
    logic [31:0] want[4];
    offs = '{32'h40000000, 32'hC0000000, 32'h80000000, 32'h00000001};
    want = '{32'h3FC90FDA, 32'hBFC90FDA, 32'hC0490FDA, 32'h30C90FDA};
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1, $urandom, offs[k]);
      n_cmp++;
      if (phase !== offs[k]) begin
        n_bad++;
        $display("FAIL sync_phase[%0d]: phase=%h required %h", k, phase, offs[k]);
      end
      for (int j = 0; j < 3; j++) begin
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (theta_valid !== (j == 2)) begin
          n_bad++;
          $display("FAIL sync_latency[%0d.%0d]: valid=%b required %b", k, j, theta_valid,
                   (j == 2));
        end
      end
      n_cmp++;
      if (theta !== want[k] || exp_theta !== want[k]) begin
        n_bad++;
        $display("FAIL sync_theta[%0d]: theta=%h model=%h required %h", k, theta, exp_theta,
                 want[k]);
      end
    end
  endtask

  task automatic test_step_sequence();
    logic [31:0] ph_tab[5];
    logic [31:0] th_tab[5];
    ph_tab = '{32'h40000000, 32'h80000000, 32'hC0000000, 32'h00000000, 32'h40000000};
    th_tab = '{32'h3FC90FDA, 32'hC0490FDA, 32'hBFC90FDA, 32'h00000000, 32'h3FC90FDA};
    tick(1'b0, 1'b1, 32'h0, 32'h0);
    repeat (3) tick(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick(i < 5, 1'b0, 32'h40000000, 32'h0);
      if (i < 5) begin
        n_cmp++;
        if (phase !== ph_tab[i]) begin
          n_bad++;
          $display("FAIL step_phase[%0d]: phase=%h required %h", i, phase, ph_tab[i]);
        end
      end
      n_cmp++;
      if (theta_valid !== (i >= 3)) begin
        n_bad++;
        $display("FAIL step_valid[%0d]: valid=%b required %b", i, theta_valid, (i >= 3));
      end else if (i >= 3) begin
        n_cmp++;
        if (theta !== th_tab[i-3]) begin
          n_bad++;
          $display("FAIL step_theta[%0d]: theta=%h required %h", i - 3, theta, th_tab[i-3]);
        end
      end
    end
  endtask

  task automatic test_step_sync_collision();
    int pulses;
    pulses = 0;
    tick(1'b1, 1'b1, 32'h10000000, 32'h40000000);
    n_cmp++;
    if (phase !== 32'h40000000) begin
      n_bad++;
      $display("FAIL collide_phase: phase=%h required 40000000", phase);
    end
    repeat (6) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0);
      if (theta_valid === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || theta !== 32'h3FC90FDA) begin
      n_bad++;
      $display("FAIL collide_out: pulses=%0d theta=%h, required 1/3FC90FDA", pulses, theta);
    end
  endtask

  task automatic test_reset_midflight();
    tick(1'b1, 1'b0, 32'h12345678 | $urandom_range(1, 255), 32'h0);
    rst = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (phase !== 32'h0 || theta !== 32'h0 || theta_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midflight_async: phase=%h theta=%h valid=%b, required 0/0/0",
               phase, theta, theta_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0);
      n_cmp++;
      if (phase !== 32'h0 || theta !== 32'h0 || theta_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL midflight_quiet[%0d]: phase=%h theta=%h valid=%b, required 0/0/0",
                 i, phase, theta, theta_valid);
      end
    end
  endtask

  task automatic test_random();
    logic st, sy;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) != 0);
      sy = ($urandom_range(0, 15) == 0);
      tick(st, sy, $urandom, $urandom);
      n_cmp++;
      if (phase !== ref_phase || theta_valid !== exp_valid || theta !== exp_theta) begin
        n_bad++;
        $display("FAIL random[%0d]: phase=%h valid=%b theta=%h, required %h/%b/%h",
                 i, phase, theta_valid, theta, ref_phase, exp_valid, exp_theta);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_vectors();
    test_step_sequence();
    test_step_sync_collision();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
